// File: rtl/rhd_offset_cal.sv
// rhd_offset_cal: MISO sampling-offset calibrator for the rhd_2048 front end.
// Sweeps one common offset over all lanes, re-runs the chip configuration at
// each step, scores each lane's ROM-ID match, and commits the centre of the
// longest contiguous passing window per lane.
module rhd_offset_cal #(
   parameter int N_LANES        = 32,
   parameter int OFS_W          = 8,
   parameter int N_OFFSETS      = 16,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       cal_start,
   output logic                       rhd_config_start,
   input  logic                       rhd_config_done,
   input  logic [N_LANES-1:0]         rhd_id_ok,
   output logic [N_LANES*OFS_W-1:0]   lane_offset,
   output logic                       cal_busy,
   output logic                       cal_done,
   output logic [N_LANES-1:0]         lane_fail,
   output logic                       cal_timeout
);

   localparam int LEN_W = $clog2(N_OFFSETS + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [OFS_W-1:0] K_LAST      = OFS_W'(N_OFFSETS - 1);
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_KICK,
      ST_WAIT,
      ST_FINAL
   } state_t;

   state_t             state;
   logic [OFS_W-1:0]   k;
   logic [SET_W-1:0]   settle_cnt;
   logic [TMR_W-1:0]   timer;

   logic [OFS_W-1:0]   cur_start  [N_LANES];
   logic [LEN_W-1:0]   cur_len    [N_LANES];
   logic [OFS_W-1:0]   best_start [N_LANES];
   logic [LEN_W-1:0]   best_len   [N_LANES];
   logic [OFS_W-1:0]   committed  [N_LANES];

   // Candidate run if this step passes: a fresh run starts at k
   logic [OFS_W-1:0]   run_start  [N_LANES];
   logic [LEN_W-1:0]   run_len    [N_LANES];

   logic               accept_start;
   logic               score_step;

   assign accept_start = (state == ST_IDLE) && cal_start;
   assign score_step   = (state == ST_WAIT) && rhd_config_done;

   // Next-run values for each lane, used only when the lane passes
   always_comb begin
      for (int i = 0; i < N_LANES; i++) begin
         run_start[i] = (cur_len[i] == '0) ? k : cur_start[i];
         run_len[i]   = cur_len[i] + 1'b1;
      end
   end

   // Sweep sequencer: settle, kick configuration, wait for done or timeout
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= ST_IDLE;
         k                <= '0;
         settle_cnt       <= '0;
         timer            <= '0;
         rhd_config_start <= 1'b0;
         cal_busy         <= 1'b0;
         cal_done         <= 1'b0;
         cal_timeout      <= 1'b0;
      end else begin
         rhd_config_start <= 1'b0;
         cal_done         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cal_start) begin
                  k           <= '0;
                  cal_timeout <= 1'b0;
                  settle_cnt  <= SETTLE_LOAD;
                  cal_busy    <= 1'b1;
                  state       <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  rhd_config_start <= 1'b1;
                  state            <= ST_KICK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_KICK: begin
               timer <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (rhd_config_done) begin
                  if (k == K_LAST) begin
                     state <= ST_FINAL;
                  end else begin
                     k          <= k + 1'b1;
                     settle_cnt <= SETTLE_LOAD;
                     state      <= ST_SETTLE;
                  end
               end else if (timer == TMR_LAST) begin
                  cal_timeout <= 1'b1;
                  cal_busy    <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_FINAL: begin
               cal_done <= 1'b1;
               cal_busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               cal_busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Per-lane window tracking and final commit of the window centre
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_LANES; i++) begin
            cur_start[i]  <= '0;
            cur_len[i]    <= '0;
            best_start[i] <= '0;
            best_len[i]   <= '0;
            committed[i]  <= '0;
         end
         lane_fail <= '0;
      end else begin
         if (accept_start) begin
            for (int i = 0; i < N_LANES; i++) begin
               cur_start[i]  <= '0;
               cur_len[i]    <= '0;
               best_start[i] <= '0;
               best_len[i]   <= '0;
            end
         end else if (score_step) begin
            for (int i = 0; i < N_LANES; i++) begin
               if (rhd_id_ok[i]) begin
                  cur_start[i] <= run_start[i];
                  cur_len[i]   <= run_len[i];
                  // Strict compare keeps the earliest of equally long runs
                  if (run_len[i] > best_len[i]) begin
                     best_start[i] <= run_start[i];
                     best_len[i]   <= run_len[i];
                  end
               end else begin
                  cur_len[i] <= '0;
               end
            end
         end
         if (state == ST_FINAL) begin
            for (int i = 0; i < N_LANES; i++) begin
               if (best_len[i] != '0) begin
                  committed[i] <= best_start[i] + OFS_W'((best_len[i] - 1'b1) >> 1);
                  lane_fail[i] <= 1'b0;
               end else begin
                  committed[i] <= '0;
                  lane_fail[i] <= 1'b1;
               end
            end
         end
      end
   end

   // During a sweep every lane sees the sweep offset; otherwise the results
   always_comb begin
      lane_offset = '0;
      for (int i = 0; i < N_LANES; i++) begin
         lane_offset[i*OFS_W +: OFS_W] = cal_busy ? k : committed[i];
      end
   end

endmodule

// File: tb/tb_rhd_offset_cal.sv
// Testbench for rhd_offset_cal: a behavioural rhd_2048 responder answers each
// kick from per-lane pass masks; expected results are computed from the masks
// when a calibration starts and compared when cal_done pulses.
module tb_rhd_offset_cal;

   localparam int NL       = 32;
   localparam int OW       = 8;
   localparam int NO       = 16;
   localparam int SC       = 16;
   localparam int TO       = 1000;
   localparam int RESP_DLY = 50;

   logic              clk = 1'b0;
   logic              rstn;
   logic              cal_start;
   logic              rhd_config_start;
   logic              rhd_config_done;
   logic [NL-1:0]     rhd_id_ok;
   logic [NL*OW-1:0]  lane_offset;
   logic              cal_busy;
   logic              cal_done;
   logic [NL-1:0]     lane_fail;
   logic              cal_timeout;

   rhd_offset_cal #(
      .N_LANES(NL), .OFS_W(OW), .N_OFFSETS(NO),
      .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .cal_start(cal_start),
      .rhd_config_start(rhd_config_start), .rhd_config_done(rhd_config_done),
      .rhd_id_ok(rhd_id_ok), .lane_offset(lane_offset), .cal_busy(cal_busy),
      .cal_done(cal_done), .lane_fail(lane_fail), .cal_timeout(cal_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NL*OW-1:0] ofs;
      logic [NL-1:0]    fail;
   } exp_t;
   exp_t sb[$];

   logic [NO-1:0] pass_mask [NL];
   int silent_step = -1;
   int spur_cnt = 0, spur_seen = 0;
   int kick_cnt = 0, done_cnt = 0, step_idx = 0, resp_cnt = 0, resp_step = 0;
   int kick_cyc [NO];
   int total = 0, bad = 0;
   int k0_g, d0_g, s_cyc_g;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Responder: answers each kick RESP_DLY cycles later with the mask bit of
   // that step; also emits requested spurious dones and counts events.
   initial begin
      rhd_config_done = 1'b0;
      rhd_id_ok       = '0;
      forever begin
         @(negedge clk);
         rhd_config_done = 1'b0;
         rhd_id_ok       = '0;
         if (cal_done) done_cnt++;
         if (spur_cnt != spur_seen) begin
            spur_seen       = spur_cnt;
            rhd_config_done = 1'b1;
            rhd_id_ok       = '0;
         end
         if (!cal_busy) begin
            step_idx = 0;
            resp_cnt = 0;
         end else begin
            if (resp_cnt > 0) begin
               resp_cnt--;
               if (resp_cnt == 0) begin
                  rhd_config_done = 1'b1;
                  for (int i = 0; i < NL; i++)
                     rhd_id_ok[i] = (resp_step < NO) ? pass_mask[i][resp_step] : 1'b0;
               end
            end
            if (rhd_config_start) begin
               kick_cnt++;
               if (step_idx < NO) kick_cyc[step_idx] = cyc;
               if (step_idx != silent_step) begin
                  resp_cnt  = RESP_DLY;
                  resp_step = step_idx;
               end
               step_idx++;
            end
         end
      end
   end

   // Reference: scan each run from its first bit, keep the first longest one
   task automatic model(output logic [NL*OW-1:0] ofs, output logic [NL-1:0] fail);
      ofs  = '0;
      fail = '0;
      for (int l = 0; l < NL; l++) begin
         int best_len, best_s, len;
         logic prev;
         best_len = 0;
         best_s   = 0;
         for (int s = 0; s < NO; s++) begin
            prev = (s == 0) ? 1'b0 : pass_mask[l][s-1];
            if (pass_mask[l][s] && !prev) begin
               len = 0;
               for (int j = s; j < NO; j++) begin
                  if (!pass_mask[l][j]) break;
                  len++;
               end
               if (len > best_len) begin
                  best_len = len;
                  best_s   = s;
               end
            end
         end
         if (best_len > 0) ofs[l*OW +: OW] = OW'(best_s + (best_len - 1) / 2);
         fail[l] = (best_len == 0);
      end
   endtask

   function automatic logic [NL*OW-1:0] all_ofs(input logic [OW-1:0] v);
      return {NL{v}};
   endfunction

   task automatic set_range(input int lane, input int lo, input int hi);
      pass_mask[lane] = '0;
      for (int s = lo; s <= hi; s++) pass_mask[lane][s] = 1'b1;
   endtask

   task automatic set_all(input int lo, input int hi);
      for (int l = 0; l < NL; l++) set_range(l, lo, hi);
   endtask

   task automatic pulse_start();
      @(negedge clk) cal_start = 1'b1;
      @(negedge clk) cal_start = 1'b0;
   endtask

   task automatic start_cal(input string tag);
      exp_t e;
      model(e.ofs, e.fail);
      sb.push_back(e);
      k0_g = kick_cnt;
      d0_g = done_cnt;
      pulse_start();
      s_cyc_g = cyc;
      chk({tag, "_busy_t1"}, cal_busy, 1);
      chk({tag, "_ofs_t1"}, lane_offset, 0);
      chk({tag, "_tmo_clr"}, cal_timeout, 0);
   endtask

   task automatic finish_cal(input string tag);
      exp_t e;
      bit seen;
      seen = 0;
      for (int n = 0; n < 5000 && !seen; n++) begin
         @(negedge clk);
         if (cal_done) seen = 1;
      end
      chk({tag, "_done_seen"}, seen, 1);
      e = sb.pop_front();
      chk({tag, "_ofs"}, lane_offset, e.ofs);
      chk({tag, "_fail"}, lane_fail, e.fail);
      chk({tag, "_busy_end"}, cal_busy, 0);
      chk({tag, "_kick0_lat"}, kick_cyc[0] - s_cyc_g, SC);
      @(negedge clk);
      chk({tag, "_kicks"}, kick_cnt - k0_g, NO);
      chk({tag, "_dones"}, done_cnt - d0_g, 1);
      chk({tag, "_done_pulse"}, cal_done, 0);
   endtask

   task automatic wait_ofs0(input string tag, input int v);
      bit seen;
      seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge clk);
         if (cal_busy && lane_offset[OW-1:0] == OW'(v)) seen = 1;
      end
      chk({tag, "_reach_ofs"}, seen, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {cal_busy, cal_done, cal_timeout, rhd_config_start}, 0);
      chk({tag, "_ofs"}, lane_offset, 0);
      chk({tag, "_fail"}, lane_fail, 0);
   endtask

   initial begin
      bit seen;
      int t_cyc, d0;
      rstn      = 1'b0;
      cal_start = 1'b0;
      set_all(3, 7);
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rstn = 1'b1;
      @(negedge clk);
      chk_zero("post_reset");

      // All lanes pass 3..7
      set_all(3, 7);
      start_cal("s1");
      finish_cal("s1");
      chk("s1_all5", lane_offset, all_ofs(8'd5));
      chk("s1_nofail", lane_fail, 0);

      // Mixed windows: tie to earliest, run ending at last step
      set_all(3, 7);
      pass_mask[0] = 16'b0000_0011_1100_0110;
      pass_mask[1] = 16'b0000_1100_0000_1100;
      pass_mask[2] = 16'b1111_0000_0000_0000;
      start_cal("s2");
      finish_cal("s2");
      chk("s2_lane0", lane_offset[0*OW +: OW], 7);
      chk("s2_lane1", lane_offset[1*OW +: OW], 2);
      chk("s2_lane2", lane_offset[2*OW +: OW], 13);

      // Lane 5 never passes
      set_all(4, 6);
      pass_mask[5] = '0;
      start_cal("s3");
      finish_cal("s3");
      chk("s3_fail", lane_fail, 32'h0000_0020);
      chk("s3_lane5", lane_offset[5*OW +: OW], 0);
      chk("s3_lane4", lane_offset[4*OW +: OW], 5);

      // Prior all-5 result, then responder silent at step 4
      set_all(3, 7);
      start_cal("s4pre");
      finish_cal("s4pre");
      silent_step = 4;
      d0 = done_cnt;
      pulse_start();
      seen = 0;
      for (int n = 0; n < 5000 && !seen; n++) begin
         @(negedge clk);
         if (cal_timeout) seen = 1;
      end
      t_cyc = cyc;
      chk("s4_tmo_seen", seen, 1);
      chk("s4_tmo_lat", t_cyc - kick_cyc[4], TO + 1);
      chk("s4_busy", cal_busy, 0);
      chk("s4_ofs", lane_offset, all_ofs(8'd5));
      repeat (5) @(negedge clk);
      chk("s4_no_done", done_cnt - d0, 0);
      chk("s4_sticky", cal_timeout, 1);
      silent_step = -1;

      // Event rejection: spurious done in SETTLE, cal_start mid-sweep
      set_all(3, 7);
      start_cal("s5");
      wait_ofs0("s5_spur", 5);
      spur_cnt++;
      wait_ofs0("s5_restart", 10);
      pulse_start();
      chk("s5_k_cont", lane_offset[OW-1:0], 10);
      finish_cal("s5");

      // Reset mid-sweep at step 9
      set_all(3, 7);
      pulse_start();
      wait_ofs0("s6_step9", 9);
      rstn = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk_zero("s6_low");
      end
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      chk_zero("s6_after");
      start_cal("s6");
      finish_cal("s6");
      chk("s6_all5", lane_offset, all_ofs(8'd5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rhd_offset_cal.md
# rhd_offset_cal

Per-lane MISO sampling-delay calibrator for the `rhd_2048` SPI front end. It sweeps one common oversample offset across all lanes and re-runs the `rhd_2048` configuration sequence at each offset, using the per-lane ROM readback result ("INTAN" ID match) as the pass indicator. It then selects each lane's offset as the centre of its longest contiguous passing window. The block sits between the system control layer and `rhd_2048` and drives that block's `config_start` and 32 `oversample_offset_*` inputs.

## Interface
Parameters:
- `N_LANES`, 32: number of MISO lanes (A1..P2).
- `OFS_W`, 8: offset width; matches the `rhd_2048` offset inputs.
- `N_OFFSETS`, 16: sweep points 0..N_OFFSETS-1; must be ≤ 2^OFS_W.
- `SETTLE_CYCLES`, 16: wait after each offset change before kicking config.
- `TIMEOUT_CYCLES`, 1_000_000: maximum wait for `rhd_config_done` per step.

Ports:
- `clk` in 1: system clock (112 MHz). Single clock domain.
- `rstn` in 1: asynchronous, active-low reset.
- `cal_start` in 1: one-cycle start request.
- `rhd_config_start` out 1: one-cycle pulse to `rhd_2048`.
- `rhd_config_done` in 1: one-cycle pulse from `rhd_2048` when the config sequence completes.
- `rhd_id_ok` in N_LANES: per-lane ROM-ID match; valid only in the cycle `rhd_config_done`=1.
- `lane_offset` out N_LANES*OFS_W: per-lane offset, lane i at bits [i*OFS_W +: OFS_W]; lane 0 = A1.
- `cal_busy` out 1: high from the cycle after an accepted start until return to IDLE.
- `cal_done` out 1: one-cycle pulse on successful completion.
- `lane_fail` out N_LANES: lane had no passing offset in the last successful calibration.
- `cal_timeout` out 1: sticky; set on abort, cleared by the next accepted `cal_start`.

## Operation
- Registers:
  - `committed[N_LANES]`: calibrated offsets.
  - Step index `k`.
  - Per-lane trackers: `cur_start`, `cur_len`, `best_start`, `best_len`. Lengths are $clog2(N_OFFSETS+1) bits; starts are OFS_W bits.
- `lane_offset` source:
  - While `cal_busy` = 1: every lane = `k`.
  - Otherwise: `committed`.
- FSM states: IDLE, SETTLE, KICK, WAIT, FINAL.
- **IDLE**
  - `cal_start`=1 → k=0, all trackers=0, `cal_timeout`=0, settle counter=SETTLE_CYCLES-1, go to SETTLE.
- **SETTLE**
  - Count down. At 0 → KICK.
- **KICK**
  - Assert `rhd_config_start` for this one cycle.
  - Clear timeout timer → WAIT.
- **WAIT** on `rhd_config_done`=1, for each lane:
  - If `rhd_id_ok[i]`: if `cur_len`=0 then `cur_start`=k. Then `cur_len`+1. If `cur_len`+1 > `best_len`, set `best` = {`cur_start`, `cur_len`+1}. The strict compare means the earliest run wins ties.
  - Otherwise: `cur_len`=0.
  - Then: if k=N_OFFSETS-1 → FINAL; else k+1, reload settle counter → SETTLE.
- **WAIT** with no done when the timer reaches TIMEOUT_CYCLES-1:
  - Set `cal_timeout`=1 → IDLE.
  - `committed` and `lane_fail` are unchanged; no `cal_done`.
- **FINAL** (one cycle), for each lane:
  - `best_len`>0: `committed` = `best_start` + ((`best_len`-1)>>1), `lane_fail`=0.
  - `best_len`=0: `committed`=0, `lane_fail`=1.
  - Then → IDLE and pulse `cal_done`.
- Ignored events:
  - `cal_start` while busy.
  - `rhd_config_done` outside WAIT.
  - `rhd_config_done` in the same cycle as KICK.

## Timing
- Reset values: all outputs 0, `lane_offset`=0, FSM=IDLE, all trackers 0.
- Reset mid-sweep: immediate return to reset values. The previously committed offsets are lost (they become 0).
- `cal_start` sampled at cycle t → `cal_busy`=1 and `lane_offset`=0 at t+1.
- First `rhd_config_start` at t+1+SETTLE_CYCLES.
- Done sampled at cycle d:
  - Not last step: new `lane_offset` at d+1; next kick at d+1+SETTLE_CYCLES.
  - Last step: FINAL at d+1. At d+2: `cal_done`=1, `cal_busy`=0, and `committed`/`lane_fail` visible.
- Timeout abort: `cal_busy`=0 and `cal_timeout`=1 from the cycle after the timer expires.
- `lane_offset` changes only at step boundaries, never between KICK and done.

## Test plan
- **All lanes pass at offsets 3..7** (N_OFFSETS=16, responder returns done 50 cycles after kick) → exactly 16 `rhd_config_start` pulses; `cal_done` once; every lane offset=5; `lane_fail`=0.
- **Lane 0 passes {1,2,6,7,8,9}; lane 1 passes {2,3,10,11}; lane 2 passes {12..15}** → lane 0 offset=7, lane 1 offset=2 (tie resolved to earliest run), lane 2 offset=13 (run ending at the final step is counted).
- **Lane 5 never passes, others pass 4..6** → `lane_fail`=32'h0000_0020; lane 5 offset=0; others offset=5.
- **Prior calibration gives all 5; responder silent at step 4** (TIMEOUT_CYCLES=1000) → `cal_timeout`=1 at 1001 cycles after the step-4 kick; `cal_busy`=0; `lane_offset` back to all 5; no `cal_done`.
- **Event rejection** → `cal_start` re-pulsed mid-sweep has no effect (k continues); a spurious `rhd_config_done` during SETTLE is not scored; after a later done, lane scores match scenario 1.
- **`rstn` low at step 9 for 3 cycles** → all outputs 0 while low and afterwards; FSM in IDLE; a new `cal_start` runs a full 16-step sweep.
